// File: rtl/rx_word_buffer.sv
// rx_word_buffer: receiver-side word buffer.
// Captures decoded words from the serial receiver over a 4-phase rdy/ack
// handshake. Good words go into a show-ahead FIFO that is drained over a
// valid/ready interface. Errored words are dropped. A sticky flag records
// any good word that was lost because the FIFO was full.
// Optional feature: define RXBUF_ERR_CNT_EN to build the saturating
// errored-word counter. Without it, err_cnt is tied to zero.
module rx_word_buffer #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4,   // power of 2, >= 2
   parameter int ECW   = 8
) (
   input  logic                     clk,
   input  logic                     reset,     // async, active-low
   input  logic                     rdyi,
   input  logic [WIDTH-1:0]         datai,
   input  logic                     erri,
   output logic                     acko,
   input  logic                     clr,
   output logic [WIDTH-1:0]         dout,
   output logic                     dvalid,
   input  logic                     dready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     overflow,
   output logic [ECW-1:0]           err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      ACK     = 2'd2
   } state_t;

   state_t                      state;
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr;
   logic [AW-1:0]               rd_ptr;
   logic                        cap;
   logic                        pop;
   logic                        wr;

   // A full FIFO still accepts a word if the head leaves in the same cycle.
   assign cap    = (state == CAPTURE);
   assign dvalid = (count != '0);
   assign full   = (count == CNT_FULL);
   assign pop    = dvalid & dready;
   assign wr     = cap & ~erri & (~full | pop);
   assign dout   = dvalid ? mem[rd_ptr] : '0;

   // Handshake FSM. acko is registered and only rises after the capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         acko  <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (rdyi) state <= CAPTURE;
            CAPTURE: begin
               state <= ACK;
               acko  <= 1'b1;
            end
            ACK:     if (!rdyi) begin
               state <= IDLE;
               acko  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               acko  <= 1'b0;
            end
         endcase
      end
   end

   // Storage array. This array has no reset because dout is gated by dvalid.
   always_ff @(posedge clk) begin
      if (wr && !clr) mem[wr_ptr] <= datai;
   end

   // Pointers, occupancy and overflow. clr takes priority over a write and a pop in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (wr && !pop)      count <= count + 1'b1;
         else if (pop && !wr) count <= count - 1'b1;
         if (cap && !erri && full && !pop) overflow <= 1'b1;
      end
   end

`ifdef RXBUF_ERR_CNT_EN
   // Saturating count of errored words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      err_cnt <= '0;
      else if (clr)                    err_cnt <= '0;
      else if (cap && erri && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
   end
`else
   assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_word_buffer.sv
// tb_rx_word_buffer: checks rx_word_buffer with directed and random handshakes.
// The reference model works at transaction level. It uses a queue of stored words,
// a sticky overflow bit and a saturating error count.
module tb_rx_word_buffer;

   localparam int WIDTH = 3;
   localparam int DEPTH = 4;
   localparam int ECW   = 8;

   logic             clk;
   logic             reset;
   logic             rdyi;
   logic [WIDTH-1:0] datai;
   logic             erri;
   logic             acko;
   logic             clr;
   logic [WIDTH-1:0] dout;
   logic             dvalid;
   logic             dready;
   logic [2:0]       count;
   logic             full;
   logic             overflow;
   logic [ECW-1:0]   err_cnt;

   rx_word_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ECW(ECW)) dut (
      .clk(clk), .reset(reset), .rdyi(rdyi), .datai(datai), .erri(erri),
      .acko(acko), .clr(clr), .dout(dout), .dvalid(dvalid), .dready(dready),
      .count(count), .full(full), .overflow(overflow), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   logic [WIDTH-1:0] q[$];
   logic             movf;
   int               merr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_err();
`ifdef RXBUF_ERR_CNT_EN
      return merr;
`else
      return 0;
`endif
   endfunction

   task automatic check_state(input string tag);
      chk({tag, ".count"},    32'(count),    32'(q.size()));
      chk({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
      chk({tag, ".dvalid"},   32'(dvalid),   32'(q.size() != 0));
      chk({tag, ".dout"},     32'(dout),     (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk({tag, ".overflow"}, 32'(overflow), 32'(movf));
      chk({tag, ".err_cnt"},  32'(err_cnt),  32'(exp_err()));
   endtask

   // The task runs one full handshake. p raises dready and c raises clr during the capture cycle.
   task automatic hs(input logic [WIDTH-1:0] d, input logic e, input logic p, input logic c);
      rdyi = 1'b1; datai = d; erri = e;
      @(posedge clk); #1;
      dready = p; clr = c;
      if (p && !c && q.size() != 0) chk("hs.pop_head", 32'(dout), 32'(q[0]));
      @(posedge clk); #1;
      dready = 1'b0; clr = 1'b0;
      if (c) begin
         q.delete(); movf = 1'b0; merr = 0;
      end else begin
         if (p && q.size() != 0) void'(q.pop_front());
         if (e) begin
            if (merr < (1 << ECW) - 1) merr++;
         end else if (q.size() < DEPTH) q.push_back(d);
         else movf = 1'b1;
      end
      chk("hs.acko_hi", 32'(acko), 32'd1);
      check_state("hs");
      rdyi = 1'b0;
      @(posedge clk); #1;
      chk("hs.acko_lo", 32'(acko), 32'd0);
   endtask

   task automatic pop_one();
      if (q.size() != 0) chk("pop.head", 32'(dout), 32'(q[0]));
      dready = 1'b1;
      @(posedge clk); #1;
      dready = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
      check_state("pop");
   endtask

   initial begin
      reset = 1'b0; rdyi = 1'b0; datai = '0; erri = 1'b0; clr = 1'b0; dready = 1'b0;
      movf = 1'b0; merr = 0;
      #2;
      check_state("reset");
      chk("reset.acko", 32'(acko), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // single word: dvalid and acko both rise after the capture edge
      hs(3'b101, 1'b0, 1'b0, 1'b0);
      pop_one();

      // six words into a 4-deep FIFO cause an overflow, then drain
      for (int i = 1; i <= 6; i++) hs(WIDTH'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pop_one();

      // errored word
      hs(3'b111, 1'b1, 1'b0, 1'b0);

      // full plus a simultaneous pop and write: the write is accepted and overflow stays 0
      hs(3'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) hs(WIDTH'(i), 1'b0, 1'b0, 1'b0);
      hs(3'd7, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) pop_one();
      pop_one();   // pop while empty is ignored

      // write plus a pop at count=1
      hs(3'd3, 1'b0, 1'b0, 1'b0);
      hs(3'd6, 1'b0, 1'b1, 1'b0);
      pop_one();

      // reset during ACK with count=2
      hs(3'd1, 1'b0, 1'b0, 1'b0);
      rdyi = 1'b1; datai = 3'd2; erri = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      q.push_back(3'd2);
      chk("rst_mid.acko_pre", 32'(acko), 32'd1);
      chk("rst_mid.count_pre", 32'(count), 32'd2);
      #2 reset = 1'b0;
      #1;
      q.delete(); movf = 1'b0; merr = 0;
      chk("rst_mid.acko", 32'(acko), 32'd0);
      check_state("rst_mid");
      rdyi = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      hs(3'd4, 1'b0, 1'b0, 1'b0);
      hs(3'd5, 1'b0, 1'b0, 1'b1);   // clr with a pending capture

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 3) == 0) pop_one();
         else hs(WIDTH'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
      end

      // error counter saturation
      for (int i = 0; i < 260; i++) hs(3'd2, 1'b1, 1'b0, 1'b0);
      check_state("sat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // safety bound
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
